qpu_exu_moitf: RTL and testbench
================================

# qpu_exu_moitf

Measurement outstanding-instruction tracking FIFO (MOITF) for the QPU execute stage. It records the qubit list of every measure instruction the dispatcher issues, holds it until the measurement result returns, and tells dispatch two things: whether a new measure can be accepted, and whether an incoming measure/FMR qubit list overlaps any pending measurement. It sits between the dispatch unit (which consumes `disp_moitf_ready` and `oitfqf_match_dispql`) and the measurement-result writeback path.

## Interface
Parameters:
- `DEPTH`, 4: number of outstanding measurements; power of two, ≥2.
- `QUBIT_NUM`, `` `QPU_QUBIT_NUM ``: qubit-list width.

Ports:
- `clk` input 1: clock; single clock domain.
- `rst_n` input 1: reset; asynchronous, active-low.
- `dis_ena` input 1: allocate an entry. Driven by `disp_moitf_ena`.
- `dis_ready` output 1: an entry is free. Drives `disp_moitf_ready`.
- `dis_qubitlist` input QUBIT_NUM: qubit list of the instruction at dispatch. Used both for allocation and for matching.
- `dis_qfren` input 1: the dispatching instruction reads qubit flags (measure or FMR); enables matching.
- `qf_match` output 1: pending-qubit overlap. Drives `oitfqf_match_dispql`.
- `ret_ena` input 1: the measurement result for the head entry has returned; pop the head.
- `ret_qubitlist` output QUBIT_NUM: qubit list of the head entry; 0 when empty.
- `qubit_flag` output QUBIT_NUM: OR of the qubit lists of all valid entries.
- `moitf_empty` output 1: no valid entries.
- `moitf_cnt` output clog2(DEPTH)+1: number of valid entries.

## Operation
- Storage is a circular buffer of DEPTH entries. Each entry holds a valid bit and a QUBIT_NUM-bit list.
- Pointers are `alc_ptr` and `ret_ptr`, each clog2(DEPTH) bits plus a wrap bit.
  - Empty: pointers equal and wrap bits equal.
  - Full: pointers equal and wrap bits differ.
- **Allocate.** When `dis_ena & dis_ready`:
  - write `dis_qubitlist` into `entry[alc_ptr]` and set its valid bit;
  - increment `alc_ptr`; the wrap bit toggles when the pointer goes from DEPTH-1 to 0.
- **Retire.** When `ret_ena & ~moitf_empty`:
  - clear `entry[ret_ptr]`, both valid bit and list (list cleared to 0);
  - increment `ret_ptr` with the same wrap rule.
- `dis_ready = ~full`.
- `moitf_empty`, `moitf_cnt` and `qubit_flag` are combinational from registered state only.
- `qf_match = dis_qfren & |(dis_qubitlist & qubit_flag)`. This is combinational from the inputs and registered state.
- `ret_qubitlist = entry[ret_ptr].list`. It reads 0 when empty, because retired entries are cleared.
- `moitf_cnt` arithmetic: `alc_ptr - ret_ptr` computed modulo 2·DEPTH using the wrap-extended pointers. Range is 0..DEPTH.

## Timing
- Reset values, applied asynchronously on `rst_n` low:
  - all entries: valid = 0, list = 0;
  - both pointers and wrap bits = 0;
  - therefore `dis_ready=1`, `moitf_empty=1`, `moitf_cnt=0`, `qubit_flag=0`, `ret_qubitlist=0`, `qf_match=0`.
- Allocation latency: an entry written at edge N is visible in `qubit_flag`, `qf_match`, `moitf_cnt` and `ret_qubitlist` from cycle N+1. There is no same-cycle bypass.
- Retire latency: an entry retired at edge N is still counted in `qf_match` and `qubit_flag` during cycle N (conservative). It disappears from cycle N+1.
- Simultaneous allocate and retire, non-empty and non-full: both occur, and `moitf_cnt` is unchanged.
- Full with `ret_ena`: retire occurs. `dis_ready` rises in the next cycle, not combinationally.
- Empty with simultaneous `dis_ena` and `ret_ena`: allocate occurs, the retire is ignored, and the count becomes 1.
- `dis_ena` while full is ignored with no state change. The bench flags it as a protocol error.
- `ret_ena` while empty is ignored with no state change. The bench flags it as a protocol error.
- Asserting `rst_n` low mid-operation discards all pending entries immediately. Outputs return to their reset values in the same cycle (asynchronous).

## Test plan
- **Reset / idle.** Release reset, with all inputs 0.
  - Required: `dis_ready=1`, `moitf_empty=1`, `moitf_cnt=0`, `qubit_flag=0`, `qf_match=0`.
- **Single measure round trip.** Allocate `dis_qubitlist=0x005`.
  - Next cycle: `qubit_flag=0x005`, `ret_qubitlist=0x005`, `moitf_cnt=1`.
  - Then `dis_qfren=1` with `dis_qubitlist=0x004` gives `qf_match=1`; `dis_qubitlist=0x002` gives `qf_match=0`.
  - Then pulse `ret_ena`: the next cycle is empty with flag 0.
- **Fill to full.** Allocate 0x001, 0x002, 0x004, 0x008 (DEPTH=4).
  - Required: `dis_ready=0`, `moitf_cnt=4`, `qubit_flag=0x00F`.
  - A fifth `dis_ena` with 0x010 changes nothing.
- **Wrap-around ordering.** Allocate 6 lists and retire them interleaved, so the pointers pass index 3→0.
  - Required: `ret_qubitlist` presents the lists strictly in allocation order.
  - Required: `moitf_cnt` matches the scoreboard every cycle.
- **Simultaneous events.**
  - Empty, with `dis_ena` and `ret_ena` on the same edge and list 0x030: count=1 and head=0x030.
  - Full, with `ret_ena` and `dis_ena` on the same edge: only the retire occurs; `dis_ready=1` the next cycle.
  - Two entries, allocate and retire on the same edge: count stays 2.
- **Reset mid-operation.** With 3 entries pending, pull `rst_n` low for 1 cycle between clock edges.
  - Required: outputs are at reset values immediately.
  - After release, a new allocation lands at index 0.

Source files
------------

// File: rtl/qpu_exu_moitf.sv
// rtl/qpu_exu_moitf.sv - measurement outstanding-instruction tracking FIFO
`ifndef QPU_QUBIT_NUM
`define QPU_QUBIT_NUM 12
`endif

module qpu_exu_moitf #(
    parameter int DEPTH     = 4,
    parameter int QUBIT_NUM = `QPU_QUBIT_NUM,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 dis_ena,
    output logic                 dis_ready,
    input  logic [QUBIT_NUM-1:0] dis_qubitlist,
    input  logic                 dis_qfren,
    output logic                 qf_match,
    input  logic                 ret_ena,
    output logic [QUBIT_NUM-1:0] ret_qubitlist,
    output logic [QUBIT_NUM-1:0] qubit_flag,
    output logic                 moitf_empty,
    output logic [AW:0]          moitf_cnt
);

    logic                 valid_q [DEPTH];
    logic [QUBIT_NUM-1:0] list_q  [DEPTH];

    // Pointers carry an extra wrap bit above the index so full and empty differ.
    logic [AW:0] alc_ptr;
    logic [AW:0] ret_ptr;

    logic full;
    logic alc_fire;
    logic ret_fire;

    // Pointer comparison decides empty/full; count is the wrap-extended difference.
    always_comb begin
        moitf_empty = (alc_ptr == ret_ptr);
        full        = (alc_ptr[AW-1:0] == ret_ptr[AW-1:0]) && (alc_ptr[AW] != ret_ptr[AW]);
        moitf_cnt   = alc_ptr - ret_ptr;
        dis_ready   = ~full;
        alc_fire    = dis_ena & ~full;
        ret_fire    = ret_ena & ~moitf_empty;
    end

    // Pending qubits are the union of every valid entry; match is a plain overlap test.
    always_comb begin
        qubit_flag = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i]) begin
                qubit_flag = qubit_flag | list_q[i];
            end
        end
        qf_match      = dis_qfren & (|(dis_qubitlist & qubit_flag));
        ret_qubitlist = list_q[ret_ptr[AW-1:0]];
    end

    // Entry storage: allocate writes at alc_ptr, retire clears at ret_ptr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                list_q[i]  <= '0;
            end
        end else begin
            // Retire first so an allocate to the same slot (only possible when
            // the buffer is full, where allocate is blocked) can never be lost.
            if (ret_fire) begin
                valid_q[ret_ptr[AW-1:0]] <= 1'b0;
                list_q[ret_ptr[AW-1:0]]  <= '0;
            end
            if (alc_fire) begin
                valid_q[alc_ptr[AW-1:0]] <= 1'b1;
                list_q[alc_ptr[AW-1:0]]  <= dis_qubitlist;
            end
        end
    end

    // Pointer advance; DEPTH is a power of two so natural overflow toggles the wrap bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alc_ptr <= '0;
            ret_ptr <= '0;
        end else begin
            if (alc_fire) begin
                alc_ptr <= alc_ptr + 1'b1;
            end
            if (ret_fire) begin
                ret_ptr <= ret_ptr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_qpu_exu_moitf.sv
// tb/tb_qpu_exu_moitf.sv - randomized bench for qpu_exu_moitf against a queue model
module tb_qpu_exu_moitf;

    localparam int DEPTH = 4;
    localparam int QN    = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          dis_ena = 1'b0;
    logic          dis_ready;
    logic [QN-1:0] dis_qubitlist = '0;
    logic          dis_qfren = 1'b0;
    logic          qf_match;
    logic          ret_ena = 1'b0;
    logic [QN-1:0] ret_qubitlist;
    logic [QN-1:0] qubit_flag;
    logic          moitf_empty;
    logic [2:0]    moitf_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int n_proto = 0;

    logic [QN-1:0] model_q[$];

    qpu_exu_moitf #(.DEPTH(DEPTH), .QUBIT_NUM(QN)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .dis_ena       (dis_ena),
        .dis_ready     (dis_ready),
        .dis_qubitlist (dis_qubitlist),
        .dis_qfren     (dis_qfren),
        .qf_match      (qf_match),
        .ret_ena       (ret_ena),
        .ret_qubitlist (ret_qubitlist),
        .qubit_flag    (qubit_flag),
        .moitf_empty   (moitf_empty),
        .moitf_cnt     (moitf_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [QN-1:0] m_flag();
        logic [QN-1:0] f = '0;
        foreach (model_q[i]) f |= model_q[i];
        return f;
    endfunction

    function automatic logic [QN-1:0] m_head();
        return (model_q.size() != 0) ? model_q[0] : '0;
    endfunction

    task automatic check_state(input string tag);
        chk({tag, "_ready"}, 32'(dis_ready), 32'(model_q.size() < DEPTH));
        chk({tag, "_empty"}, 32'(moitf_empty), 32'(model_q.size() == 0));
        chk({tag, "_cnt"},   32'(moitf_cnt), 32'(model_q.size()));
        chk({tag, "_flag"},  32'(qubit_flag), 32'(m_flag()));
        chk({tag, "_head"},  32'(ret_qubitlist), 32'(m_head()));
    endtask

    // Called just after a rising edge: check state, drive, check match, clock, update model.
    task automatic cycle(input logic ena, input logic [QN-1:0] ql, input logic qfren,
                         input logic ret, input string tag);
        bit do_alc;
        bit do_ret;
        check_state(tag);
        dis_ena = ena;
        dis_qubitlist = ql;
        dis_qfren = qfren;
        ret_ena = ret;
        #1;
        chk({tag, "_qfm"}, 32'(qf_match), 32'(qfren && ((ql & m_flag()) != 0)));
        if (ena && model_q.size() == DEPTH) n_proto++;
        if (ret && model_q.size() == 0) n_proto++;
        do_alc = ena && (model_q.size() < DEPTH);
        do_ret = ret && (model_q.size() != 0);
        @(posedge clk);
        if (do_ret) void'(model_q.pop_front());
        if (do_alc) model_q.push_back(ql);
        #1;
        dis_ena = 1'b0;
        ret_ena = 1'b0;
        dis_qfren = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // reset / idle
        chk("rst_ready", 32'(dis_ready), 1);
        chk("rst_empty", 32'(moitf_empty), 1);
        chk("rst_cnt", 32'(moitf_cnt), 0);
        chk("rst_flag", 32'(qubit_flag), 0);
        chk("rst_qfm", 32'(qf_match), 0);

        // single round trip
        cycle(1'b1, 12'h005, 1'b0, 1'b0, "rt_alc");
        chk("rt_flag", 32'(qubit_flag), 32'h005);
        chk("rt_head", 32'(ret_qubitlist), 32'h005);
        chk("rt_cnt", 32'(moitf_cnt), 1);
        dis_qfren = 1'b1; dis_qubitlist = 12'h004; #1;
        chk("rt_match_hit", 32'(qf_match), 1);
        dis_qubitlist = 12'h002; #1;
        chk("rt_match_miss", 32'(qf_match), 0);
        dis_qfren = 1'b0;
        @(posedge clk); #1;
        cycle(1'b0, 12'h000, 1'b0, 1'b1, "rt_ret");
        chk("rt_empty_after", 32'(moitf_empty), 1);
        chk("rt_flag_after", 32'(qubit_flag), 0);

        // fill to full
        cycle(1'b1, 12'h001, 1'b0, 1'b0, "fill0");
        cycle(1'b1, 12'h002, 1'b0, 1'b0, "fill1");
        cycle(1'b1, 12'h004, 1'b0, 1'b0, "fill2");
        cycle(1'b1, 12'h008, 1'b1, 1'b0, "fill3");
        chk("full_ready", 32'(dis_ready), 0);
        chk("full_cnt", 32'(moitf_cnt), 4);
        chk("full_flag", 32'(qubit_flag), 32'h00F);
        cycle(1'b1, 12'h010, 1'b1, 1'b0, "fill_over");
        chk("over_cnt", 32'(moitf_cnt), 4);
        chk("over_flag", 32'(qubit_flag), 32'h00F);
        chk("over_head", 32'(ret_qubitlist), 32'h001);

        // full with retire and allocate on the same edge: only retire
        cycle(1'b1, 12'h020, 1'b0, 1'b1, "full_both");
        chk("full_both_ready", 32'(dis_ready), 1);
        chk("full_both_cnt", 32'(moitf_cnt), 3);
        chk("full_both_head", 32'(ret_qubitlist), 32'h002);

        // drain, then wrap-around ordering with interleaved traffic
        cycle(1'b0, 12'h000, 1'b0, 1'b1, "drain0");
        cycle(1'b0, 12'h000, 1'b0, 1'b1, "drain1");
        // two entries, alloc+retire same edge: count stays
        cycle(1'b1, 12'h100, 1'b0, 1'b0, "two_a");
        chk("two_cnt_pre", 32'(moitf_cnt), 2);
        cycle(1'b1, 12'h200, 1'b0, 1'b1, "two_both");
        chk("two_cnt_post", 32'(moitf_cnt), 2);
        chk("two_head", 32'(ret_qubitlist), 32'h100);
        cycle(1'b0, 12'h000, 1'b0, 1'b1, "wr_d0");
        cycle(1'b0, 12'h000, 1'b0, 1'b1, "wr_d1");
        begin
            logic [QN-1:0] lists[6] = '{12'h011, 12'h022, 12'h044, 12'h088, 12'h101, 12'h202};
            for (int i = 0; i < 6; i++) begin
                cycle(1'b1, lists[i], 1'b1, (i % 2) == 1, "wrap");
            end
            while (model_q.size() != 0) cycle(1'b0, 12'h000, 1'b0, 1'b1, "wrap_drain");
        end

        // empty with alloc and retire on the same edge
        cycle(1'b1, 12'h030, 1'b0, 1'b1, "emp_both");
        chk("emp_both_cnt", 32'(moitf_cnt), 1);
        chk("emp_both_head", 32'(ret_qubitlist), 32'h030);
        cycle(1'b0, 12'h000, 1'b0, 1'b1, "emp_clr");

        // reset mid-operation with three pending entries
        cycle(1'b1, 12'h003, 1'b0, 1'b0, "mr0");
        cycle(1'b1, 12'h00C, 1'b0, 1'b0, "mr1");
        cycle(1'b1, 12'h030, 1'b0, 1'b0, "mr2");
        chk("mr_cnt_pre", 32'(moitf_cnt), 3);
        #1 rst_n = 1'b0;
        #1;
        chk("mr_ready", 32'(dis_ready), 1);
        chk("mr_empty", 32'(moitf_empty), 1);
        chk("mr_cnt", 32'(moitf_cnt), 0);
        chk("mr_flag", 32'(qubit_flag), 0);
        chk("mr_head", 32'(ret_qubitlist), 0);
        #1 rst_n = 1'b1;
        model_q.delete();
        @(posedge clk); #1;
        cycle(1'b1, 12'h0A5, 1'b0, 1'b0, "mr_alc");
        chk("mr_alc_ptr", 32'(dut.alc_ptr), 1);
        chk("mr_alc_head", 32'(ret_qubitlist), 32'h0A5);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [QN-1:0] ql;
            logic e, r, q;
            ql = QN'($urandom);
            if ($urandom_range(0, 3) == 0) ql = m_flag() & QN'($urandom);
            e = ($urandom_range(0, 99) < 55);
            r = ($urandom_range(0, 99) < 45);
            q = ($urandom_range(0, 1) == 1);
            cycle(e, ql, q, r, "rnd");
        end
        check_state("final");

        $display("protocol violations exercised (ignored by design): %0d", n_proto);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
